// File: rtl/div_unit_pkg.sv
// Shared parameters for the RV32M divide unit.
//   XLEN     : operand/result width
//   div_op_e : op select encodings (DIV/DIVU/REM/REMU)
//   state_e  : control FSM state encodings
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    DIV_OP  = 2'b00,
    DIVU_OP = 2'b01,
    REM_OP  = 2'b10,
    REMU_OP = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // op[0]=0 selects the signed flavours, op[1]=1 selects remainder
  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
//   rem_i : partial remainder (always < dvs_i)
//   quo_i : quotient/dividend shift register
//   dvs_i : divisor magnitude
//   rem_o : next partial remainder
//   quo_o : next quotient register, new quotient bit in [0]
module div_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          borrow;

  // One bit wider than XLEN: rem_sh can reach 2*dvs-1, and the top bit of
  // the difference is the borrow that decides restore vs keep.
  assign rem_sh = {rem_i, quo_i[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_i};
  assign borrow = diff[XLEN];

  assign rem_o = borrow ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV, DIVU, REM, REMU), one quotient bit/clock.
//   clk, rst_n : clock, async active-low reset
//   start      : request strobe, sampled only while idle
//   op         : operation select (div_op_e)
//   dividend   : rs1
//   divisor    : rs2
//   busy       : operation in flight (state != IDLE)
//   done       : one-cycle pulse, result valid
//   result     : quotient or remainder, held until next done
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  div_op_e         op_q, op_d;
  logic            qneg_q, qneg_d;     // quotient must be negated
  logic            rneg_q, rneg_d;     // remainder takes dividend sign
  logic            special_q, special_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  // Operand decode at the request boundary
  div_op_e         op_in;
  logic            sgn_in, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign op_in  = div_op_e'(op);
  assign sgn_in = op_is_signed(op_in);
  assign a_neg  = sgn_in & dividend[XLEN-1];
  assign b_neg  = sgn_in & divisor[XLEN-1];
  assign a_mag  = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag  = b_neg ? (~divisor  + 1'b1) : divisor;

  logic [XLEN-1:0] step_rem, step_quo;

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= DIV_OP;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      special_q <= special_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    special_d = special_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op_in;
          dvs_d  = b_mag;
          cnt_d  = '0;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (divisor == '0) begin
            // RISC-V defines these; rem/quo hold raw final values
            special_d = 1'b1;
            quo_d     = '1;
            rem_d     = dividend;
            state_d   = ST_FIX;
          end else if (sgn_in && dividend == INT_MIN && divisor == '1) begin
            special_d = 1'b1;
            quo_d     = dividend;
            rem_d     = '0;
            state_d   = ST_FIX;
          end else begin
            special_d = 1'b0;
            quo_d     = a_mag;
            rem_d     = '0;
            state_d   = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (special_q)
          result_d = op_is_rem(op_q) ? rem_q : quo_q;
        else if (op_is_rem(op_q))
          result_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
        else
          result_d = qneg_q ? (~quo_q + 1'b1) : quo_q;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RV32M semantics with plain language arithmetic (C-style truncation)
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
    case (o)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Issue one request; counts clock edges after acceptance until done and
  // busy samples over that span. Optionally pokes a stray start at poke_at.
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int poke_at, output logic [31:0] res, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; op = 2'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (lat == poke_at) begin
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    if (lat >= 100) begin
      errors++;
      $display("FAIL timeout: no done within 100 cycles (op %0d)", o);
    end
    chk("busy_low_at_done", {31'b0, busy}, 32'd0);
    res = result;
  endtask

  task automatic watch_no_done(input string name, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk(name, cnt, 0);
  endtask

  logic [31:0] res, first_res;
  int lat, bcnt;

  initial begin
    vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    vecs.push_back('{2'b11, 32'd7,          32'd2,          32'd1,          33});
    vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b10, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
    vecs.push_back('{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
    vecs.push_back('{2'b00, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b10, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8,  1});
    vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
    vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'd1,          32'd0,          33});
    vecs.push_back('{2'b01, 32'd3,          32'd10,         32'd0,          33});

    // reset state
    #12;
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_done",   {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // directed table (consecutive entries also exercise done-cycle restart)
    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, -1, res, lat, bcnt);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].lat);
    end

    // result holds and done drops after the pulse
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("result_held", result, vecs[vecs.size()-1].exp);

    // stray start at cycle 10 of an operation is ignored
    run(2'b01, 32'd100, 32'd7, 10, res, lat, bcnt);
    chk("poke_result", res, 32'd14);
    chk("poke_latency", lat, 33);
    watch_no_done("poke_no_queued_done", 40);

    // explicit back-to-back: second start lands in the done cycle
    run(2'b01, 32'd1000, 32'd9, -1, first_res, lat, bcnt);
    chk("b2b_first", first_res, 32'd111);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL b2b_in_done_cycle: done=%0b required 1", done);
    end
    run(2'b11, 32'd1000, 32'd9, -1, res, lat, bcnt);
    chk("b2b_second", res, 32'd1);
    chk("b2b_latency", lat, 33);

    // randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b, e;
      int          el;
      o = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      e  = ref_div(o, a, b);
      el = (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      run(o, a, b, -1, res, lat, bcnt);
      chk($sformatf("rand%0d op%0d %08h/%08h", i, o, a, b), res, e);
      chk($sformatf("rand%0d_latency", i), lat, el);
    end

    // reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd12345; divisor = 32'd10;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy",   {31'b0, busy}, 32'd0);
    chk("midrst_done",   {31'b0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    watch_no_done("midrst_no_late_done", 40);

    // unit still usable after reset
    run(2'b01, 32'd12345, 32'd10, -1, res, lat, bcnt);
    chk("post_rst_result", res, 32'd1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
